// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX stage and its forwarding muxes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package id_ex_stage_pkg;

  localparam int ID_EX_XLEN = 32;  // datapath width
  localparam int ID_EX_RA_W = 5;   // register address width

  // ALU operation encodings carried through this stage untouched.
  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_XOR  = 3'b001,
    ALU_SLL  = 3'b010,
    ALU_ADD  = 3'b011,
    ALU_SUB  = 3'b100,
    ALU_MUL  = 3'b101,
    ALU_SRAI = 3'b110
  } alu_op_e;

  // Operand source chosen by a forwarding mux.
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  // Control bits that ride along with the instruction.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Purpose: pick one operand from EX/MEM, MEM/WB or the register-file copy.
// Latency: purely combinational, zero cycles.
// Backpressure: none; re-evaluates every cycle on whatever it is given.
//
// Ports: rs_addr/rs_data    registered source address and register-file data
//        exmem_*/memwb_*    forward sources (dest address, write enable, value)
//        fwd_data/fwd_sel   selected value and which source supplied it
// Build option: ID_EX_FWD_EN enables forwarding; without it the register-file
// data always passes through and the forward sources are ignored.
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = ID_EX_XLEN,
  parameter int RA_W = ID_EX_RA_W
) (
  input  logic [RA_W-1:0] rs_addr,
  input  logic [XLEN-1:0] rs_data,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] fwd_data,
  output fwd_sel_e        fwd_sel
);

`ifdef ID_EX_FWD_EN
  // EX/MEM is the younger producer, so it wins over MEM/WB.
  // x0 is hardwired zero and must never be overridden by a forward.
  always_comb begin
    fwd_sel = FWD_RF;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_addr)) begin
      fwd_sel = FWD_EXMEM;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_addr)) begin
      fwd_sel = FWD_MEMWB;
    end
  end

  always_comb begin
    fwd_data = rs_data;
    case (fwd_sel)
      FWD_EXMEM: fwd_data = exmem_result;
      FWD_MEMWB: fwd_data = memwb_result;
      default:   fwd_data = rs_data;
    endcase
  end
`else
  assign fwd_sel  = FWD_RF;
  assign fwd_data = rs_data;

  logic unused_fwd;
  assign unused_fwd = ^{rs_addr, exmem_rd, exmem_reg_write, exmem_result,
                        memwb_rd, memwb_reg_write, memwb_result};
`endif

endmodule

// File: rtl/id_ex_stage.sv
// Purpose: ID/EX pipeline register with RAW forwarding and load-use detection.
// Latency: one cycle ID->registered fields; operands combinational from those.
// Backpressure: stall_i holds the entry, flush_i loads a bubble (flush wins).
//
// Ports: clk_i/rst_i          clock, synchronous active-high reset
//        stall_i/flush_i      hold entry / insert bubble
//        *_i (ID side)        decoded operands, immediate, addresses, controls
//        exmem_*/memwb_*      forward sources from later stages
//        alu_*_o              ALU operands and op; store_data_o forwarded rs2
//        rd_addr_o, ctrl *_o  registered destination and control bits
//        valid_o, load_use_o  entry holds an instruction; load-use hazard vs ID
// Build option: ID_EX_FWD_EN enables the forwarding muxes (see fwd_mux).
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = ID_EX_XLEN,
  parameter int RA_W = ID_EX_RA_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [RA_W-1:0] rs1_addr_i,
  input  logic [RA_W-1:0] rs2_addr_i,
  input  logic [RA_W-1:0] rd_addr_i,
  input  logic [2:0]      alu_ctrl_i,
  input  logic            alu_src_i,
  input  logic            reg_write_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic            mem_to_reg_i,
  input  logic [RA_W-1:0] exmem_rd_i,
  input  logic            exmem_reg_write_i,
  input  logic [XLEN-1:0] exmem_result_i,
  input  logic [RA_W-1:0] memwb_rd_i,
  input  logic            memwb_reg_write_i,
  input  logic [XLEN-1:0] memwb_result_i,
  output logic [XLEN-1:0] alu_data1_o,
  output logic [XLEN-1:0] alu_data2_o,
  output logic [2:0]      alu_ctrl_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [RA_W-1:0] rd_addr_o,
  output logic            reg_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            mem_to_reg_o,
  output logic            valid_o,
  output logic            load_use_o
);

  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic [RA_W-1:0] rs1_addr_q;
  logic [RA_W-1:0] rs2_addr_q;
  logic [RA_W-1:0] rd_addr_q;
  logic [2:0]      alu_ctrl_q;
  logic            alu_src_q;
  ctrl_t           ctrl_q;
  logic            valid_q;

  // Reset and flush both produce an all-zero bubble; stall holds everything.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      alu_ctrl_q <= ALU_AND;
      alu_src_q  <= 1'b0;
      ctrl_q     <= '0;
      valid_q    <= 1'b0;
    end else if (!stall_i) begin
      rs1_data_q <= rs1_data_i;
      rs2_data_q <= rs2_data_i;
      imm_q      <= imm_i;
      rs1_addr_q <= rs1_addr_i;
      rs2_addr_q <= rs2_addr_i;
      rd_addr_q  <= rd_addr_i;
      alu_ctrl_q <= alu_ctrl_i;
      alu_src_q  <= alu_src_i;
      ctrl_q     <= '{reg_write:  reg_write_i,
                      mem_read:   mem_read_i,
                      mem_write:  mem_write_i,
                      mem_to_reg: mem_to_reg_i};
      valid_q    <= 1'b1;
    end
  end

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  fwd_sel_e        rs1_sel;
  fwd_sel_e        rs2_sel;

  // Forwarding keys off the registered addresses, so a stalled entry keeps
  // picking up results as they retire behind it.
  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .rs_addr         (rs1_addr_q),
    .rs_data         (rs1_data_q),
    .exmem_rd        (exmem_rd_i),
    .exmem_reg_write (exmem_reg_write_i),
    .exmem_result    (exmem_result_i),
    .memwb_rd        (memwb_rd_i),
    .memwb_reg_write (memwb_reg_write_i),
    .memwb_result    (memwb_result_i),
    .fwd_data        (rs1_fwd),
    .fwd_sel         (rs1_sel)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .rs_addr         (rs2_addr_q),
    .rs_data         (rs2_data_q),
    .exmem_rd        (exmem_rd_i),
    .exmem_reg_write (exmem_reg_write_i),
    .exmem_result    (exmem_result_i),
    .memwb_rd        (memwb_rd_i),
    .memwb_reg_write (memwb_reg_write_i),
    .memwb_result    (memwb_result_i),
    .fwd_data        (rs2_fwd),
    .fwd_sel         (rs2_sel)
  );

  // Select codes are kept for debug visibility but drive nothing here.
  logic unused_sel;
  assign unused_sel = ^{rs1_sel, rs2_sel};

  assign alu_data1_o  = rs1_fwd;
  assign alu_data2_o  = alu_src_q ? imm_q : rs2_fwd;
  assign store_data_o = rs2_fwd;  // stores need rs2 even when the ALU uses imm

  assign alu_ctrl_o   = alu_ctrl_q;
  assign rd_addr_o    = rd_addr_q;
  assign reg_write_o  = ctrl_q.reg_write;
  assign mem_read_o   = ctrl_q.mem_read;
  assign mem_write_o  = ctrl_q.mem_write;
  assign mem_to_reg_o = ctrl_q.mem_to_reg;
  assign valid_o      = valid_q;

  // A load here cannot forward to the instruction now in ID in time.
  assign load_use_o = ctrl_q.mem_read && valid_q && (rd_addr_q != '0) &&
                      ((rd_addr_q == rs1_addr_i) || (rd_addr_q == rs2_addr_i));

endmodule

// File: tb/tb_id_ex_stage.sv
// Purpose: scoreboard bench for id_ex_stage against a behavioural model.
// Latency: expected values queued per cycle, checked on the falling edge.
// Backpressure: stall/flush/reset driven directly and randomly.
module tb_id_ex_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush;
  logic [31:0] rs1_data, rs2_data, imm;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [2:0]  alu_ctrl;
  logic        alu_src, reg_write, mem_read, mem_write, mem_to_reg;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_wr, memwb_wr;
  logic [31:0] exmem_res, memwb_res;

  logic [31:0] d1_o, d2_o, st_o;
  logic [2:0]  op_o;
  logic [4:0]  rd_o;
  logic        rw_o, mr_o, mw_o, m2r_o, valid_o, lu_o;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .imm_i(imm),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rd_addr_i(rd_addr),
    .alu_ctrl_i(alu_ctrl), .alu_src_i(alu_src),
    .reg_write_i(reg_write), .mem_read_i(mem_read),
    .mem_write_i(mem_write), .mem_to_reg_i(mem_to_reg),
    .exmem_rd_i(exmem_rd), .exmem_reg_write_i(exmem_wr), .exmem_result_i(exmem_res),
    .memwb_rd_i(memwb_rd), .memwb_reg_write_i(memwb_wr), .memwb_result_i(memwb_res),
    .alu_data1_o(d1_o), .alu_data2_o(d2_o), .alu_ctrl_o(op_o),
    .store_data_o(st_o), .rd_addr_o(rd_o),
    .reg_write_o(rw_o), .mem_read_o(mr_o), .mem_write_o(mw_o),
    .mem_to_reg_o(m2r_o), .valid_o(valid_o), .load_use_o(lu_o)
  );

  // Model of the instruction held in the stage.
  typedef struct {
    logic [31:0] rs1_data, rs2_data, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd;
    logic [2:0]  op;
    logic        src, rw, mr, mw, m2r, valid;
  } entry_t;

  typedef struct {
    logic [31:0] d1, d2, st;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        rw, mr, mw, m2r, valid, lu;
  } exp_t;

  entry_t m;
  exp_t   q[$];
  int     total  = 0;
  int     passed = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else passed++;
  endfunction

  // Value an instruction reading register a sees, given current retirements.
  function automatic logic [31:0] operand(logic [4:0] a, logic [31:0] rf);
`ifdef ID_EX_FWD_EN
    if (exmem_wr && exmem_rd != 5'd0 && exmem_rd == a) return exmem_res;
    if (memwb_wr && memwb_rd != 5'd0 && memwb_rd == a) return memwb_res;
`endif
    return rf;
  endfunction

  function automatic void model_edge();
    if (rst || flush) begin
      m = '{default: 0};
    end else if (!stall) begin
      m = '{rs1_data: rs1_data, rs2_data: rs2_data, imm: imm,
            rs1_addr: rs1_addr, rs2_addr: rs2_addr, rd: rd_addr,
            op: alu_ctrl, src: alu_src, rw: reg_write, mr: mem_read,
            mw: mem_write, m2r: mem_to_reg, valid: 1'b1};
    end
  endfunction

  // Queue the expected outputs for the current inputs, then advance one edge.
  task automatic tick();
    exp_t e;
    e.d1    = operand(m.rs1_addr, m.rs1_data);
    e.st    = operand(m.rs2_addr, m.rs2_data);
    e.d2    = m.src ? m.imm : e.st;
    e.op    = m.op;
    e.rd    = m.rd;
    e.rw    = m.rw;
    e.mr    = m.mr;
    e.mw    = m.mw;
    e.m2r   = m.m2r;
    e.valid = m.valid;
    e.lu    = m.mr && m.valid && m.rd != 5'd0 && (m.rd == rs1_addr || m.rd == rs2_addr);
    q.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear();
    rst = 0; stall = 0; flush = 0;
    rs1_data = 0; rs2_data = 0; imm = 0;
    rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
    alu_ctrl = 0; alu_src = 0;
    reg_write = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0;
    exmem_rd = 0; exmem_wr = 0; exmem_res = 0;
    memwb_rd = 0; memwb_wr = 0; memwb_res = 0;
  endtask

  task automatic rand_id();
    rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
    rs1_addr = 5'($urandom_range(0, 7));
    rs2_addr = 5'($urandom_range(0, 7));
    rd_addr  = 5'($urandom_range(0, 7));
    alu_ctrl = 3'($urandom_range(0, 6));
    alu_src  = 1'($urandom_range(0, 1));
    reg_write = 1'($urandom_range(0, 1));
    mem_read  = 1'($urandom_range(0, 1));
    mem_write = 1'($urandom_range(0, 1));
    mem_to_reg = 1'($urandom_range(0, 1));
  endtask

  task automatic rand_fwd();
    exmem_rd = 5'($urandom_range(0, 7)); exmem_wr = 1'($urandom_range(0, 1));
    exmem_res = $urandom;
    memwb_rd = 5'($urandom_range(0, 7)); memwb_wr = 1'($urandom_range(0, 1));
    memwb_res = $urandom;
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("alu_data1", d1_o, e.d1);
        chk("alu_data2", d2_o, e.d2);
        chk("store_data", st_o, e.st);
        chk("alu_ctrl", 32'(op_o), 32'(e.op));
        chk("rd_addr", 32'(rd_o), 32'(e.rd));
        chk("reg_write", 32'(rw_o), 32'(e.rw));
        chk("mem_read", 32'(mr_o), 32'(e.mr));
        chk("mem_write", 32'(mw_o), 32'(e.mw));
        chk("mem_to_reg", 32'(m2r_o), 32'(e.m2r));
        chk("valid", 32'(valid_o), 32'(e.valid));
        chk("load_use", 32'(lu_o), 32'(e.lu));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m = '{default: 0};
    // Reset with random ID and forward inputs.
    clear(); rand_id(); rand_fwd(); rst = 1;
    @(posedge clk); model_edge(); #1;
    tick(); rand_id(); rand_fwd(); tick();

    // EX/MEM has priority over MEM/WB; then MEM/WB once EX/MEM drops.
    clear(); rs1_addr = 5; rs1_data = 32'h11; reg_write = 1; rd_addr = 9;
    tick();
    stall = 1; rand_id();
    exmem_rd = 5; exmem_wr = 1; exmem_res = 32'h22;
    memwb_rd = 5; memwb_wr = 1; memwb_res = 32'h33;
    tick();
    exmem_wr = 0;
    tick();

    // x0 is never forwarded.
    clear(); rs2_addr = 0; rs2_data = 0; alu_src = 0;
    tick();
    stall = 1; exmem_rd = 0; exmem_wr = 1; exmem_res = 32'hDEAD;
    memwb_rd = 0; memwb_wr = 1; memwb_res = 32'hBEEF;
    tick();

    // Immediate path: ALU sees imm, store still sees forwarded rs2.
    clear(); alu_src = 1; imm = 32'hFFFF_FFF0; rs2_addr = 3; rs2_data = 32'h55;
    mem_write = 1;
    tick();
    stall = 1; exmem_rd = 3; exmem_wr = 1; exmem_res = 32'h7;
    tick();

    // Load-use: hazard seen, hazard unit flushes, bubble follows.
    clear(); mem_read = 1; mem_to_reg = 1; reg_write = 1; rd_addr = 7;
    tick();
    clear(); rs1_addr = 7; rs2_addr = 2; reg_write = 1; flush = 1;
    tick();
    clear(); rs1_addr = 7;
    tick();
    // Load to x0 never raises the hazard.
    clear(); mem_read = 1; rd_addr = 0;
    tick();
    clear(); rs1_addr = 0; rs2_addr = 0;
    tick();

    // Stall holds an ADD for three cycles, then stall+flush yields a bubble.
    clear(); alu_ctrl = 3'b011; rs1_data = 32'hA5A5_0001; rs2_data = 32'h0102_0304;
    rs1_addr = 1; rs2_addr = 2; rd_addr = 4; reg_write = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      rand_id(); stall = 1;
      tick();
    end
    rand_id(); stall = 1; flush = 1;
    tick();
    clear();
    tick();

    // Random traffic, including reset arriving during a stall.
    for (int i = 0; i < 400; i++) begin
      rand_id(); rand_fwd();
      rst   = ($urandom_range(0, 99) < 3);
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 10);
      tick();
    end

    clear();
    tick();
    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and forwarding stage directly upstream of the EX-stage ALU. It captures decoded operands, immediate, destination and control bits from ID each cycle. It drives the ALU's two 32-bit operands and 3-bit control, after resolving RAW hazards by forwarding from EX/MEM and MEM/WB. It also flags load-use hazards so the hazard unit can stall ID/IF.

## Interface
Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register address width

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous reset, active-high
- stall_i  in  1  hold all registered fields
- flush_i  in  1  load a bubble
- rs1_data_i, rs2_data_i  in  XLEN  register-file read data from ID
- imm_i  in  XLEN  sign-extended immediate
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  RA_W  ID register addresses
- alu_ctrl_i  in  3  ALU op: 000 AND, 001 XOR, 010 SLL, 011 ADD, 100 SUB, 101 MUL, 110 SRAI
- alu_src_i  in  1  1 = operand 2 is the immediate
- reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i  in  1  control bits
- exmem_rd_i  in  RA_W; exmem_reg_write_i  in  1; exmem_result_i  in  XLEN  EX/MEM forward source
- memwb_rd_i  in  RA_W; memwb_reg_write_i  in  1; memwb_result_i  in  XLEN  MEM/WB forward source
- alu_data1_o, alu_data2_o  out  XLEN  ALU operands
- alu_ctrl_o  out  3  registered ALU op
- store_data_o  out  XLEN  forwarded rs2 value for stores
- rd_addr_o  out  RA_W  registered destination
- reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o  out  1  registered control bits
- valid_o  out  1  stage holds a real instruction
- load_use_o  out  1  combinational load-use hazard against the instruction currently in ID

## Operation
- Register update precedence per edge: rst_i, then flush_i, then stall_i, then normal capture.
- Normal capture: all ID inputs are registered and valid_o is set to 1.
- Reset and flush (bubble): every registered field is set to 0, including valid_o, all control bits and alu_ctrl 000.
- Stall: every registered field holds its value.
- Forward select for rs1, then identically for rs2. Choose the first match:
  - EX/MEM, if exmem_reg_write_i and exmem_rd_i != 0 and exmem_rd_i == registered rs1_addr.
  - MEM/WB, if memwb_reg_write_i and memwb_rd_i != 0 and memwb_rd_i == registered rs1_addr.
  - Otherwise the registered register-file data.
- Address x0 is never forwarded.
- alu_data1_o is the forwarded rs1 value.
- alu_data2_o is the registered imm when registered alu_src is 1, otherwise the forwarded rs2 value.
- store_data_o is always the forwarded rs2 value, independent of alu_src.
- load_use_o = registered mem_read and valid_o and rd_addr_o != 0 and (rd_addr_o == rs1_addr_i or rd_addr_o == rs2_addr_i).
  - It is combinational on the current ID inputs.
  - The hazard unit responds by asserting flush_i on this stage and stalling IF/ID for one cycle.
- No arithmetic is performed in this block. Operands pass through at full XLEN width.

## Timing
- Latency: ID inputs appear on the registered outputs one cycle after the capturing edge.
- alu_data1_o, alu_data2_o and store_data_o are combinational from the registered fields and the current forward inputs. There are no added cycles.
- load_use_o is valid in the same cycle as the ID inputs.
- Reset value of every output:
  - Registered outputs are 0.
  - alu_data1_o = alu_data2_o = store_data_o = 0, unless a forward input matches address 0. That cannot happen because x0 is excluded.
  - load_use_o = 0.
- stall_i and flush_i in the same cycle: flush wins.
- rst_i asserted mid-stall: the stage is cleared on that edge.
- A held (stalled) entry keeps re-evaluating forwarding every cycle, so it picks up results that retire while it waits.

## Configuration
- ID_EX_FWD_EN defined: forwarding muxes are present as described above.
- ID_EX_FWD_EN undefined:
  - alu_data1_o is the registered rs1_data.
  - The rs2 path uses the registered rs2_data.
  - The exmem_* and memwb_* inputs are ignored.
  - load_use_o behaviour is unchanged.

## Structure
- Shared package/header holds:
  - XLEN and RA_W constants.
  - ALU control encodings 000–110.
  - Forward-select encoding: 00 register file, 01 MEM/WB, 10 EX/MEM.
- One sub-module, fwd_mux. It takes the registered address and data plus both forward sources, and returns the selected value and select code. It is instantiated twice (rs1, rs2).

## Test plan
- Reset: hold rst_i with random ID inputs. Expect all outputs 0, valid_o 0 and load_use_o 0 after the edge.
- EX/MEM forward priority:
  - Capture rs1_addr 5, rs1_data 0x11.
  - Drive exmem_rd 5 with reg_write and result 0x22, and memwb_rd 5 with reg_write and result 0x33.
  - Expect alu_data1_o 0x22.
  - Drop exmem_reg_write and expect 0x33.
- x0 exclusion: capture rs2_addr 0, rs2_data 0, alu_src 0, with exmem_rd 0, reg_write 1, result 0xDEAD. Expect alu_data2_o 0 and store_data_o 0.
- Immediate path: capture alu_src 1, imm 0xFFFFFFF0, rs2_addr 3, with exmem forwarding 0x7 to x3. Expect alu_data2_o 0xFFFFFFF0 and store_data_o 0x7.
- Load-use:
  - Capture mem_read 1, rd 7.
  - Next cycle present rs1_addr_i 7 and expect load_use_o 1.
  - Assert flush_i and expect a bubble (valid_o 0, reg_write_o 0) next cycle.
- Stall/flush: capture ADD (alu_ctrl 011). Then:
  - Assert stall_i for 3 cycles and expect the outputs to hold.
  - Assert stall_i and flush_i together and expect the bubble.
